// File: rtl/pipe_deco_exe_hs.sv
// Decode-to-execute pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Optional stall/flush statistics counters are enabled by defining PIPE_DE_STATS_EN.
module pipe_deco_exe_hs #(
    parameter int BITS   = 32,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   immExtD,
    input  logic [BITS-1:0]   RD1D,
    input  logic [BITS-1:0]   RD2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic [CTRL_W-1:0] ctrlD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BITS-1:0]   immExtE,
    output logic [BITS-1:0]   RD1E,
    output logic [BITS-1:0]   RD2E,
    output logic [ADDR_W-1:0] WA3E,
    output logic [CTRL_W-1:0] ctrlE
`ifdef PIPE_DE_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int PW = 3 * BITS + ADDR_W + CTRL_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] d_word;
    logic          in_fire;
    logic          out_fire;
    logic          load_main_d;
    logic          load_main_skid;
    logic          load_skid;

    assign d_word    = {immExtD, RD1D, RD2D, WA3D, ctrlD};
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign {immExtE, RD1E, RD2E, WA3E, ctrlE} = main_q;

    always_comb begin
        next_state     = state;
        load_main_d    = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_d = 1'b1;
                    next_state  = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_d = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    next_state = TWO;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    next_state     = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
        // Flush overrides every handshake outcome computed above.
        if (flush) begin
            next_state = EMPTY;
        end
    end

    // in_ready is registered from next_state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
            if (load_main_d) begin
                main_q <= d_word;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= d_word;
            end
        end
    end

`ifdef PIPE_DE_STATS_EN
    // Saturating counters; only reset clears them, flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (state != EMPTY) && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
